// File: rtl/pin_teclado.sv
// -----------------------------------------------------------------------------
// pin_teclado -- two-digit BCD keypad entry for a gate controller.
//
// Keys 0..9 are collected into a two-digit code {digit1,digit2}. Enter on a
// full, non-zero code presents it on Pin for exactly one cycle (Enviando=1).
// After that a holdoff of GUARD cycles follows, during which every strobe is
// ignored. Code 00 is reserved as the idle value of Pin and cannot be sent.
//
// Optional feature (macro PIN_TIMEOUT_EN):
//   When defined, a partial or complete but unsent entry is discarded after
//   TIMEOUT idle cycles, and Error pulses. When undefined, the idle counter is
//   held at zero, synthesizes away, and entries persist indefinitely.
//
// All outputs are registered. Reset is synchronous and active-high.
// -----------------------------------------------------------------------------
module pin_teclado #(
  parameter int GUARD   = 4,   // holdoff cycles after a send (1..15)
  parameter int TIMEOUT = 16   // idle cycles before discard (2..255)
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] Tecla,
  input  logic       Tecla_valida,
  input  logic       Enter,
  input  logic       Borrar,
  output logic [7:0] Pin,
  output logic       Enviando,
  output logic [1:0] Digitos,
  output logic       Error
);

  // FSM encoding
  localparam logic [2:0] ESPERA      = 3'd0;
  localparam logic [2:0] UN_DIGITO   = 3'd1;
  localparam logic [2:0] DOS_DIGITOS = 3'd2;
  localparam logic [2:0] ENVIO       = 3'd3;
  localparam logic [2:0] GUARDA      = 3'd4;

  // Last count value of each counter; a counter at this value expires on the
  // current edge.
  localparam logic [3:0] GUARD_LAST   = 4'(GUARD - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

`ifdef PIN_TIMEOUT_EN
  localparam logic TIMEOUT_EN = 1'b1;
`else
  localparam logic TIMEOUT_EN = 1'b0;
`endif

  // State and datapath registers
  logic [2:0] state_r;
  logic [3:0] hi_r;
  logic [3:0] lo_r;
  logic [3:0] guard_cnt_r;
  logic [7:0] idle_cnt_r;

  // Next-state values
  logic [2:0] state_s;
  logic [3:0] hi_s;
  logic [3:0] lo_s;
  logic [3:0] guard_cnt_s;
  logic [7:0] idle_cnt_s;

  // Next values of the registered outputs
  logic [7:0] pin_s;
  logic       env_s;
  logic       err_s;
  logic [1:0] dig_s;

  // Decoded conditions
  logic key_ok_s;
  logic timeout_hit_s;
  logic code_zero_s;

  assign key_ok_s      = (Tecla <= 4'd9);
  assign code_zero_s   = ({hi_r, lo_r} == 8'h00);
  assign timeout_hit_s = TIMEOUT_EN && (idle_cnt_r == TIMEOUT_LAST);

  // Next-state and output decode; Borrar beats Enter beats Tecla_valida, and
  // lower-priority strobes in the same cycle are simply dropped.
  always_comb begin
    state_s     = state_r;
    hi_s        = hi_r;
    lo_s        = lo_r;
    guard_cnt_s = 4'd0;
    idle_cnt_s  = 8'd0;
    pin_s       = 8'h00;
    env_s       = 1'b0;
    err_s       = 1'b0;

    case (state_r)
      ESPERA: begin
        if (Borrar) begin
          hi_s = 4'd0;
          lo_s = 4'd0;
        end else if (Enter) begin
          err_s = 1'b1;                 // nothing to submit
        end else if (Tecla_valida) begin
          if (key_ok_s) begin
            hi_s    = Tecla;
            state_s = UN_DIGITO;
          end else begin
            err_s = 1'b1;               // not a decimal digit
          end
        end else begin
          state_s = ESPERA;
        end
      end

      UN_DIGITO: begin
        if (Borrar) begin
          hi_s    = 4'd0;
          lo_s    = 4'd0;
          state_s = ESPERA;
        end else if (Enter) begin
          err_s = 1'b1;                 // incomplete code, keep the digit
        end else if (Tecla_valida) begin
          if (key_ok_s) begin
            lo_s    = Tecla;
            state_s = DOS_DIGITOS;
          end else begin
            err_s = 1'b1;
          end
        end else if (timeout_hit_s) begin
          hi_s    = 4'd0;
          lo_s    = 4'd0;
          err_s   = 1'b1;
          state_s = ESPERA;
        end else begin
          idle_cnt_s = TIMEOUT_EN ? (idle_cnt_r + 8'd1) : 8'd0;
        end
      end

      DOS_DIGITOS: begin
        if (Borrar) begin
          hi_s    = 4'd0;
          lo_s    = 4'd0;
          state_s = ESPERA;
        end else if (Enter) begin
          if (code_zero_s) begin
            // 00 is the idle value of Pin, so it can never be sent
            hi_s    = 4'd0;
            lo_s    = 4'd0;
            err_s   = 1'b1;
            state_s = ESPERA;
          end else begin
            pin_s   = {hi_r, lo_r};
            env_s   = 1'b1;
            state_s = ENVIO;
          end
        end else if (Tecla_valida) begin
          err_s = 1'b1;                 // entry full: no shift, no overwrite
        end else if (timeout_hit_s) begin
          hi_s    = 4'd0;
          lo_s    = 4'd0;
          err_s   = 1'b1;
          state_s = ESPERA;
        end else begin
          idle_cnt_s = TIMEOUT_EN ? (idle_cnt_r + 8'd1) : 8'd0;
        end
      end

      ENVIO: begin
        // Pin is already on the output this cycle; strobes are ignored
        hi_s        = 4'd0;
        lo_s        = 4'd0;
        guard_cnt_s = 4'd0;
        state_s     = GUARDA;
      end

      GUARDA: begin
        if (guard_cnt_r == GUARD_LAST) begin
          guard_cnt_s = 4'd0;
          state_s     = ESPERA;
        end else begin
          guard_cnt_s = guard_cnt_r + 4'd1;
        end
      end

      default: begin
        hi_s    = 4'd0;
        lo_s    = 4'd0;
        state_s = ESPERA;
      end
    endcase
  end

  // Digit count shown on Digitos, derived from the state being entered
  always_comb begin
    case (state_s)
      UN_DIGITO:   dig_s = 2'd1;
      DOS_DIGITOS: dig_s = 2'd2;
      default:     dig_s = 2'd0;
    endcase
  end

  // State, datapath and counter registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r     <= ESPERA;
      hi_r        <= 4'd0;
      lo_r        <= 4'd0;
      guard_cnt_r <= 4'd0;
      idle_cnt_r  <= 8'd0;
    end else begin
      state_r     <= state_s;
      hi_r        <= hi_s;
      lo_r        <= lo_s;
      guard_cnt_r <= guard_cnt_s;
      idle_cnt_r  <= idle_cnt_s;
    end
  end

  // Registered outputs; reset also cancels a send that is in flight
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Pin      <= 8'h00;
      Enviando <= 1'b0;
      Digitos  <= 2'd0;
      Error    <= 1'b0;
    end else begin
      Pin      <= pin_s;
      Enviando <= env_s;
      Digitos  <= dig_s;
      Error    <= err_s;
    end
  end

endmodule
